// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam word_t RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: stall holds everything, flush or missing instruction inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  logic  load,
  input  word_t instr,
  input  word_t pc,
  output word_t instr_q,
  output word_t pc_q,
  output word_t pc_plus4_q,
  output logic  valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!stall) begin
      if (flush || !load) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else begin
        instr_q    <= instr;
        pc_q       <= pc;
        pc_plus4_q <= pc + 32'd4;
        valid_q    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC, req/ack instruction-memory handshake, redirect handling and IF/ID register.
//  state   | meaning
//  S_FETCH | request outstanding at pc; ack data is used unless a redirect arrives with it
//  S_HOLD  | fetched word parked in hold_instr while decode is stalled; no request
//  S_DROP  | redirect arrived mid-request; wait out the ack at the old address, then go to pend_pc
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stallD,
  input  logic  flushD,
  input  logic  branch_taken,
  input  word_t branch_target,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_ack,
  input  word_t imem_rdata,
  output word_t instrD,
  output word_t pcD,
  output word_t pc_plus4D,
  output logic  validD
);

  fetch_state_t state_q, state_n;
  word_t pc_q, pc_n;
  word_t hold_instr_q, hold_instr_n;
  word_t hold_pc_q, hold_pc_n;
  word_t pend_pc_q, pend_pc_n;

  logic  instr_avail;
  word_t load_instr;
  word_t load_pc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      pend_pc_q    <= '0;
    end else begin
      pc_q         <= pc_n;
      hold_instr_q <= hold_instr_n;
      hold_pc_q    <= hold_pc_n;
      pend_pc_q    <= pend_pc_n;
    end
  end

  // Redirects are taken regardless of stallD; the PC stays put while a request is unacked.
  always_comb begin
    state_n      = state_q;
    pc_n         = pc_q;
    hold_instr_n = hold_instr_q;
    hold_pc_n    = hold_pc_q;
    pend_pc_n    = pend_pc_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pc_n = branch_target;
          end else if (!stallD) begin
            pc_n = pc_q + 32'd4;
          end else begin
            hold_instr_n = imem_rdata;
            hold_pc_n    = pc_q;
            state_n      = S_HOLD;
          end
        end else if (branch_taken) begin
          pend_pc_n = branch_target;
          state_n   = S_DROP;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_n    = branch_target;
          state_n = S_FETCH;
        end else if (!stallD) begin
          pc_n    = pc_q + 32'd4;
          state_n = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          pc_n    = branch_taken ? branch_target : pend_pc_q;
          state_n = S_FETCH;
        end else if (branch_taken) begin
          pend_pc_n = branch_target;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_avail = 1'b0;
    load_instr  = imem_rdata;
    load_pc     = pc_q;
    case (state_q)
      S_FETCH: begin
        imem_req    = !rst;
        instr_avail = imem_ack && !branch_taken;
      end
      S_HOLD: begin
        instr_avail = !branch_taken;
        load_instr  = hold_instr_q;
        load_pc     = hold_pc_q;
      end
      S_DROP:  imem_req = !rst;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (stallD),
    .flush      (flushD),
    .load       (instr_avail),
    .instr      (load_instr),
    .pc         (load_pc),
    .instr_q    (instrD),
    .pc_q       (pcD),
    .pc_plus4_q (pc_plus4D),
    .valid_q    (validD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: memory responder with variable latency, scoreboard of the
// architectural fetch stream (sequential +4, latest redirect target wins) checked by a monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stallD        (stallD),
    .flushD        (flushD),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instrD        (instrD),
    .pcD           (pcD),
    .pc_plus4D     (pc_plus4D),
    .validD        (validD)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_deliv = 0;

  // Instruction memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h2408_0005;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  logic        rst_k = 1'b1;
  int          p_stall = 0;
  int          p_bt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  logic        force_bt = 1'b0;
  logic [31:0] force_tgt = '0;

  // Memory responder state
  logic        outstanding = 1'b0;
  logic [31:0] req_addr = '0;
  int          cnt = 0;
  logic        had_br = 1'b0;
  logic        exp_load = 1'b0;

  function automatic logic pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic step();
    logic [31:0] t;
    @(negedge clk);
    rst = rst_k;
    t = $urandom;
    t[1:0] = 2'b00;
    stallD        = pct(p_stall);
    branch_taken  = force_bt || pct(p_bt);
    branch_target = force_bt ? force_tgt : t;
    flushD        = branch_taken && pct(50);
    if (rst_k) begin
      stallD = 1'b0;
      branch_taken = 1'b0;
      flushD = 1'b0;
    end
    #1;
    exp_load = 1'b0;
    if (rst) begin
      imem_ack = 1'b0;
      outstanding = 1'b0;
      chk("req_low_in_reset", {31'd0, imem_req}, 32'd0);
    end else if (imem_req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        req_addr = imem_addr;
        cnt = $urandom_range(lat_max, lat_min);
        had_br = 1'b0;
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      if (cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        exp_load = !branch_taken && !stallD && !had_br;
        outstanding = 1'b0;
      end else begin
        cnt--;
        imem_ack = 1'b0;
      end
      if (outstanding && branch_taken) had_br = 1'b1;
    end else begin
      imem_ack = 1'b0;
    end
  endtask

  // Scoreboard: expected PC of the next instruction entering IF/ID.
  logic [31:0] exp_q[$];
  logic [31:0] prev_instr = '0, prev_pc = '0, prev_pc4 = '0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] e;
    #2;
    if (rst) begin
      chk("rst_validD", {31'd0, validD}, 32'd0);
      chk("rst_instrD", instrD, 32'h0000_0000);
      chk("rst_pcD", pcD, 32'd0);
      chk("rst_pc_plus4D", pc_plus4D, 32'd0);
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
    end else begin
      if (stallD) begin
        chk("stall_hold_instrD", instrD, prev_instr);
        chk("stall_hold_pcD", pcD, prev_pc);
        chk("stall_hold_validD", {31'd0, validD}, {31'd0, prev_valid});
      end else begin
        if (exp_load) chk("one_cycle_latency_validD", {31'd0, validD}, 32'd1);
        if (branch_taken) chk("redirect_bubble_validD", {31'd0, validD}, 32'd0);
        if (branch_taken && flushD) chk("flush_bubble_instrD", instrD, 32'h0000_0000);
        if (validD) begin
          n_deliv++;
          if (exp_q.size() == 0) begin
            chk("unexpected_instr_pcD", pcD, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("pcD", pcD, e);
            chk("pc_plus4D", pc_plus4D, e + 32'd4);
            chk("instrD", instrD, mem_word(e));
            exp_q.push_back(e + 32'd4);
          end
        end
      end
      if (branch_taken) begin
        exp_q.delete();
        exp_q.push_back(branch_target);
      end
    end
    prev_instr = instrD;
    prev_pc    = pcD;
    prev_pc4   = pc_plus4D;
    prev_valid = validD;
  end

  initial begin
    rst_k = 1'b1;
    repeat (3) step();
    rst_k = 1'b0;

    // zero-wait memory, sequential stream
    lat_min = 0; lat_max = 0;
    repeat (24) step();

    // fixed 3-cycle memory latency
    lat_min = 2; lat_max = 2;
    repeat (20) step();

    // reset in the middle of a request
    rst_k = 1'b1;
    step();
    rst_k = 1'b0;
    repeat (12) step();

    // random latency, stalls, redirects and flushes
    lat_min = 0; lat_max = 3;
    p_stall = 25; p_bt = 8;
    repeat (600) step();

    // wrap-around across 2^32 with zero-wait memory
    p_stall = 0; p_bt = 0;
    lat_min = 0; lat_max = 0;
    repeat (6) step();
    force_bt = 1'b1; force_tgt = 32'hFFFF_FFF8;
    step();
    force_bt = 1'b0;
    repeat (10) step();

    rst_k = 1'b1;
    repeat (2) step();
    rst_k = 1'b0;
    step();
    @(posedge clk);
    #3;
    chk("enough_deliveries", {31'd0, (n_deliv > 100)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
